// File: rtl/alu_sched_pkg.sv
// Shared types and default widths for the round-robin ALU scheduler.
// Imported by rr_pick and alu_rr_sched.
package alu_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } sched_state_t;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_OP_W   = 4;
   localparam int DEF_RES_W  = 5;
   localparam int CNT_W      = 8;

endpackage

// File: rtl/alu_rr_sched_rr_pick.sv
// Round-robin picker: first valid requester at or above ptr, with wrap.
// Purely combinational; returns one-hot grant, its index and an any flag.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   int j;

   // Rotating search starting at ptr; the first hit wins
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = (int'(ptr) + i) % NUM_REQ;
         if (!any && valid[j]) begin
            any      = 1'b1;
            idx      = ID_W'(j);
            grant[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational ALU among NUM_REQ units.
// Optional macro ALU_RR_SCHED_PERF_EN adds per-requester grant counters.
module alu_rr_sched
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int OP_W    = DEF_OP_W,
   parameter int RES_W   = DATA_W + 1,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*OP_W-1:0]   req_op,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [OP_W-1:0]           alu_op,
   input  logic [RES_W-1:0]          alu_result,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
`ifdef ALU_RR_SCHED_PERF_EN
   output logic [RES_W-1:0]          rsp_result,
   output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
`else
   output logic [RES_W-1:0]          rsp_result
`endif
);

   sched_state_t        state, state_nx;
   logic [ID_W-1:0]     ptr;
   logic [NUM_REQ-1:0]  gnt;
   logic [ID_W-1:0]     gidx;
   logic                gany;
   logic                load, capture, done;
   logic [DATA_W-1:0]   sel_a, sel_b;
   logic [OP_W-1:0]     sel_op;
   logic [ID_W-1:0]     ptr_nx;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (gnt),
      .idx   (gidx),
      .any   (gany)
   );

   // Grant is offered only while idle and out of reset
   assign req_ready = (state == IDLE && !rst) ? gnt : '0;

   // Operand mux driven by the one-hot grant
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_a  = req_a[i*DATA_W +: DATA_W];
            sel_b  = req_b[i*DATA_W +: DATA_W];
            sel_op = req_op[i*OP_W +: OP_W];
         end
      end
   end

   assign ptr_nx = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);

   // Next-state logic and per-state action strobes
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      capture  = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (gany) begin
               load     = 1'b1;
               state_nx = EXEC;
            end
         end
         EXEC: begin
            capture  = 1'b1;
            state_nx = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, pointer, ALU operand and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
      end else begin
         state <= state_nx;
         if (load) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            rsp_id <= gidx;
            ptr    <= ptr_nx;
         end
         if (capture) begin
            rsp_result <= alu_result;
            rsp_valid  <= 1'b1;
         end else if (done) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_RR_SCHED_PERF_EN
   logic [CNT_W-1:0] cnt [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      // Saturating count of accepted requests for requester g
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt[g] <= '0;
         end else if (load && gnt[g] && cnt[g] != '1) begin
            cnt[g] <= cnt[g] + CNT_W'(1);
         end
      end
      assign grant_cnt[g*CNT_W +: CNT_W] = cnt[g];
   end
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed self-checking bench for alu_rr_sched with an adder ALU stub.
// Define ALU_RR_SCHED_PERF_EN to also exercise the grant counters.
module tb_alu_rr_sched;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int OW = 4;
   localparam int RW = 5;
   localparam int IW = 2;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_a;
   logic [N*DW-1:0] req_b;
   logic [N*OW-1:0] req_op;
   logic [DW-1:0]   alu_a;
   logic [DW-1:0]   alu_b;
   logic [OW-1:0]   alu_op;
   logic [RW-1:0]   alu_result;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [RW-1:0]   rsp_result;
`ifdef ALU_RR_SCHED_PERF_EN
   logic [N*8-1:0]  grant_cnt;
`endif

   int total = 0;
   int bad   = 0;

   alu_rr_sched #(
      .NUM_REQ (N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
`ifdef ALU_RR_SCHED_PERF_EN
      .rsp_result (rsp_result),
      .grant_cnt  (grant_cnt)
`else
      .rsp_result (rsp_result)
`endif
   );

   assign alu_result = {1'b0, alu_a} + {1'b0, alu_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [RW-1:0] er [N];
   logic          seen;

   initial begin
      rst       = 1'b1;
      req_valid = 4'b0001;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b1;
      er[0] = 5'd3;
      er[1] = 5'd7;
      er[2] = 5'd11;
      er[3] = 5'd20;

      // reset state
      tick();
      tick();
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rvalid", 32'(rsp_valid), 32'h0);
      chk("rst_alu_a", 32'(alu_a), 32'h0);
      chk("rst_result", 32'(rsp_result), 32'h0);
      rst       = 1'b0;
      req_valid = '0;

      // single request from req0: 2+2
      req_a[3:0]  = 4'd2;
      req_b[3:0]  = 4'd2;
      req_op[3:0] = 4'd1;
      req_valid   = 4'b0001;
      #1;
      chk("single_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("exec_a", 32'(alu_a), 32'd2);
      chk("exec_b", 32'(alu_b), 32'd2);
      chk("exec_op", 32'(alu_op), 32'd1);
      chk("exec_rvalid", 32'(rsp_valid), 32'h0);
      chk("exec_ready", 32'(req_ready), 32'h0);
      tick();
      chk("single_rvalid", 32'(rsp_valid), 32'h1);
      chk("single_id", 32'(rsp_id), 32'd0);
      chk("single_res", 32'(rsp_result), 32'd4);
      tick();
      chk("single_done", 32'(rsp_valid), 32'h0);
      chk("retain_a", 32'(alu_a), 32'd2);

      // all four continuously valid, starting from ptr=0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_a  = {4'd9, 4'd5, 4'd3, 4'd1};
      req_b  = {4'd11, 4'd6, 4'd4, 4'd2};
      req_op = {4'd3, 4'd2, 4'd1, 4'd0};
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rr_ready%0d", k), 32'(req_ready),
             32'(1 << (k % 4)));
         tick();
         tick();
         chk($sformatf("rr_rvalid%0d", k), 32'(rsp_valid), 32'h1);
         chk($sformatf("rr_id%0d", k), 32'(rsp_id), 32'(k % 4));
         chk($sformatf("rr_res%0d", k), 32'(rsp_result),
             32'(er[k % 4]));
         tick();
         chk($sformatf("rr_gap%0d", k), 32'(rsp_valid), 32'h0);
      end

      // backpressure: ptr=2, hold response for 5 cycles
      rsp_ready = 1'b0;
      chk("bp_ready", 32'(req_ready), 32'b0100);
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_rvalid%0d", c), 32'(rsp_valid), 32'h1);
         chk($sformatf("bp_id%0d", c), 32'(rsp_id), 32'd2);
         chk($sformatf("bp_res%0d", c), 32'(rsp_result), 32'd11);
         chk($sformatf("bp_noready%0d", c), 32'(req_ready), 32'h0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_hold", 32'(rsp_valid), 32'h1);
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
      tick();
      chk("bp_release", 32'(rsp_valid), 32'h0);

      // wrap: ptr=3, req0 and req3 both valid
      req_valid = 4'b1001;
      #1;
      chk("wrap_ready3", 32'(req_ready), 32'b1000);
      tick();
      tick();
      chk("wrap_id3", 32'(rsp_id), 32'd3);
      chk("wrap_res3", 32'(rsp_result), 32'd20);
      tick();
      chk("wrap_ready0", 32'(req_ready), 32'b0001);
      tick();
      tick();
      chk("wrap_id0", 32'(rsp_id), 32'd0);
      chk("wrap_res0", 32'(rsp_result), 32'd3);
      tick();

      // reset during EXEC drops the op
      req_valid = 4'b0010;
      #1;
      chk("mid_ready", 32'(req_ready), 32'b0010);
      tick();
      rst       = 1'b1;
      req_valid = '0;
      tick();
      chk("mid_rvalid", 32'(rsp_valid), 32'h0);
      chk("mid_alu_a", 32'(alu_a), 32'h0);
      chk("mid_alu_b", 32'(alu_b), 32'h0);
      chk("mid_alu_op", 32'(alu_op), 32'h0);
      rst  = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         seen = seen | rsp_valid;
      end
      chk("mid_no_rsp", 32'(seen), 32'h0);
      req_valid = 4'b1111;
      #1;
      chk("mid_ptr0", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      tick();
      tick();
      chk("mid_after", 32'(rsp_valid), 32'h0);

`ifdef ALU_RR_SCHED_PERF_EN
      // saturating grant counters
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("cnt_rst", grant_cnt, 32'h0);
      req_valid = 4'b0010;
      for (int k = 0; k < 300; k++) begin
         tick();
         tick();
         tick();
      end
      req_valid = 4'b0001;
      for (int k = 0; k < 2; k++) begin
         tick();
         tick();
         tick();
      end
      req_valid = 4'b1000;
      tick();
      tick();
      tick();
      req_valid = '0;
      tick();
      chk("cnt_sat1", 32'(grant_cnt[15:8]), 32'd255);
      chk("cnt_all", grant_cnt, {8'd1, 8'd0, 8'd255, 8'd2});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
